// File: rtl/exp_avg_pkg.sv
// rtl/exp_avg_pkg.sv - shared types, defaults and the floor/round shift for exp_avg_filter.
// Macro EXP_AVG_ROUND_EN switches every right shift to round-half-up.
package exp_avg_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int unsigned Q_FRAC              = 15;
  localparam int          DEFAULT_ALPHA       = 4096;
  localparam int unsigned DEFAULT_ALPHA_SHIFT = 3;

`ifdef EXP_AVG_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // Arithmetic right shift: floor, or round-half-up when ROUND_EN is set.
  function automatic logic signed [63:0] q_shift(input logic signed [63:0] v,
                                                 input int unsigned      sh);
    logic signed [63:0] r;
    r = v;
    if (ROUND_EN && sh != 0) r = v + (64'sd1 <<< (sh - 1));
    return r >>> sh;
  endfunction

endpackage

// File: rtl/exp_avg_q15_mul.sv
// rtl/exp_avg_q15_mul.sv - signed multiply by a non-negative coefficient, then scale by 2^-SHIFT.
// Scaling uses q_shift, so EXP_AVG_ROUND_EN also affects this helper.
module exp_avg_q15_mul
  import exp_avg_pkg::*;
#(
  parameter int          A_W   = 16,
  parameter int          C_W   = 17,
  parameter int unsigned SHIFT = Q_FRAC
) (
  input  logic signed [A_W-1:0]     a,
  input  logic signed [C_W-1:0]     coef,
  output logic signed [A_W+C_W-1:0] p
);

  localparam int P_W = A_W + C_W;

  logic signed [P_W-1:0] prod;

  assign prod = P_W'(a) * P_W'(coef);
  assign p    = P_W'(q_shift(64'(prod), SHIFT));

endmodule

// File: rtl/exp_avg_filter.sv
// rtl/exp_avg_filter.sv - first-order EMA low-pass filter in three parallel forms.
// Macro EXP_AVG_ROUND_EN selects round-half-up instead of floor for every shift.
module exp_avg_filter
  import exp_avg_pkg::*;
#(
  parameter int          DATA_W      = Q_FRAC + 1,
  parameter int          ALPHA       = DEFAULT_ALPHA,
  parameter int unsigned ALPHA_SHIFT = DEFAULT_ALPHA_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] q,
  output logic signed [DATA_W-1:0] q_simplified,
  output logic signed [DATA_W-1:0] q_mul_simplified
);

  localparam int unsigned F   = DATA_W - 1;
  localparam int          C_W = DATA_W + 1;
  localparam int          P_W = 2 * DATA_W + 1;
  localparam int          S_W = P_W + 1;

  localparam logic signed [C_W-1:0] ALPHA_C = C_W'(ALPHA);
  localparam logic signed [C_W-1:0] BETA_C  = C_W'((1 << F) - ALPHA);

  logic signed [P_W-1:0]    p_d;
  logic signed [P_W-1:0]    p_y;
  logic signed [S_W-1:0]    sum_q;
  logic signed [DATA_W:0]   diff_m;
  logic signed [DATA_W:0]   diff_s;
  logic signed [S_W-1:0]    p_m;
  logic signed [DATA_W-1:0] q_next;
  logic signed [DATA_W-1:0] qm_next;
  logic signed [DATA_W-1:0] qs_next;

  // Two-multiplier form: products stay unscaled so the sum is shifted only once.
  exp_avg_q15_mul #(.A_W(DATA_W), .C_W(C_W), .SHIFT(0)) u_mul_d (
    .a    (d),
    .coef (ALPHA_C),
    .p    (p_d)
  );

  exp_avg_q15_mul #(.A_W(DATA_W), .C_W(C_W), .SHIFT(0)) u_mul_y (
    .a    (q),
    .coef (BETA_C),
    .p    (p_y)
  );

  assign sum_q  = S_W'(p_d) + S_W'(p_y);
  assign q_next = DATA_W'(q_shift(64'(sum_q), F));

  // Single-multiplier form scales a*(d-y) inside the helper.
  assign diff_m = C_W'(d) - C_W'(q_mul_simplified);

  exp_avg_q15_mul #(.A_W(C_W), .C_W(C_W), .SHIFT(F)) u_mul_m (
    .a    (diff_m),
    .coef (ALPHA_C),
    .p    (p_m)
  );

  assign qm_next = q_mul_simplified + DATA_W'(p_m);

  assign diff_s  = C_W'(d) - C_W'(q_simplified);
  assign qs_next = q_simplified + DATA_W'(q_shift(64'(diff_s), ALPHA_SHIFT));

  // The result always lies between y and d, so truncation back to DATA_W cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      q                <= '0;
      q_simplified     <= '0;
      q_mul_simplified <= '0;
    end else begin
      q                <= q_next;
      q_simplified     <= qs_next;
      q_mul_simplified <= qm_next;
    end
  end

endmodule

// File: tb/tb_exp_avg_filter.sv
// tb/tb_exp_avg_filter.sv - directed self-checking bench for exp_avg_filter.
module tb_exp_avg_filter;
  import exp_avg_pkg::*;

  localparam real PI = 3.14159265358979323846;

`ifdef EXP_AVG_ROUND_EN
  localparam int R1 = 4096, R2 = 7680, IMP2 = 3584, IMP_END = 4;
  localparam int POS_END = 32764, NEG_END = -32764;
`else
  localparam int R1 = 4095, R2 = 7679, IMP2 = 3583, IMP_END = 0;
  localparam int POS_END = 32760, NEG_END = -32768;
`endif

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  sample_t d = '0;
  sample_t qa, qsa, qma, qb, qsb, qmb, qc, qsc, qmc;
  int      checks = 0;
  int      failures = 0;
  longint  m_a = 0, m_bq = 0, m_bs = 0;

  always #10 clk = ~clk;

  exp_avg_filter dut_a (
    .clk (clk), .reset (reset), .d (d),
    .q (qa), .q_simplified (qsa), .q_mul_simplified (qma)
  );

  exp_avg_filter #(.ALPHA(3000)) dut_b (
    .clk (clk), .reset (reset), .d (d),
    .q (qb), .q_simplified (qsb), .q_mul_simplified (qmb)
  );

  exp_avg_filter #(.ALPHA(32768), .ALPHA_SHIFT(0)) dut_c (
    .clk (clk), .reset (reset), .d (d),
    .q (qc), .q_simplified (qsc), .q_mul_simplified (qmc)
  );

  function automatic longint sh(input longint v, input int s);
    longint r;
    r = v;
`ifdef EXP_AVG_ROUND_EN
    if (s > 0) r = v + (longint'(1) <<< (s - 1));
`endif
    return r >>> s;
  endfunction

  task automatic step(input int x);
    d = sample_t'(x);
    @(posedge clk);
    #1;
    if (reset) begin
      m_a = 0; m_bq = 0; m_bs = 0;
    end else begin
      m_a  = sh(4096 * longint'(x) + 28672 * m_a, 15);
      m_bq = sh(3000 * longint'(x) + 29768 * m_bq, 15);
      m_bs = m_bs + sh(longint'(x) - m_bs, 3);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; step(0); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(32767); step(32767);
    checks++;
    if (qa !== 0 || qsa !== 0 || qma !== 0) begin
      failures++; $display("FAIL reset_hold q=%0d qs=%0d qm=%0d expected 0", qa, qsa, qma);
    end
    reset = 1'b0;
    step(32767);
    checks++;
    if (qa !== R1 || qsa !== R1 || qma !== R1) begin
      failures++; $display("FAIL release_1 q=%0d qs=%0d qm=%0d expected %0d", qa, qsa, qma, R1);
    end
    step(32767);
    checks++;
    if (qa !== R2 || qsa !== R2 || qma !== R2) begin
      failures++; $display("FAIL release_2 q=%0d qs=%0d qm=%0d expected %0d", qa, qsa, qma, R2);
    end
    repeat (18) step(32767);
    checks++;
    if (qa !== m_a || qsa !== m_a || qma !== m_a) begin
      failures++; $display("FAIL hold_20 q=%0d qs=%0d qm=%0d expected %0d", qa, qsa, qma, m_a);
    end
    reset = 1'b1; step(32767);
    checks++;
    if (qa !== 0 || qsa !== 0 || qma !== 0) begin
      failures++; $display("FAIL midstream_reset q=%0d qs=%0d qm=%0d expected 0", qa, qsa, qma);
    end
    reset = 1'b0;
  endtask

  task automatic test_impulse();
    int     bad = 0;
    longint prev;
    do_reset();
    step(32767);
    checks++;
    if (qa !== R1 || qsa !== R1 || qma !== R1) begin
      failures++; $display("FAIL impulse_1 q=%0d qs=%0d qm=%0d expected %0d", qa, qsa, qma, R1);
    end
    step(0);
    checks++;
    if (qa !== IMP2 || qsa !== IMP2 || qma !== IMP2) begin
      failures++; $display("FAIL impulse_2 q=%0d qs=%0d qm=%0d expected %0d", qa, qsa, qma, IMP2);
    end
    prev = qa;
    for (int k = 0; k < 200; k++) begin
      step(0);
      if (qa !== qsa || qa !== qma || qa > prev) bad++;
      prev = qa;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL impulse_decay bad_cycles=%0d expected 0", bad);
    end
    checks++;
    if (qa !== IMP_END || qsa !== IMP_END || qma !== IMP_END) begin
      failures++; $display("FAIL impulse_end q=%0d qs=%0d qm=%0d expected %0d", qa, qsa, qma, IMP_END);
    end
  endtask

  task automatic test_step();
    int bad = 0;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      step(32767);
      if (qa < 0 || qsa < 0 || qma < 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL step_wrap bad_cycles=%0d expected 0", bad);
    end
    checks++;
    if (qa !== POS_END || qsa !== POS_END || qma !== POS_END) begin
      failures++; $display("FAIL step_settle q=%0d qs=%0d qm=%0d expected %0d", qa, qsa, qma, POS_END);
    end
  endtask

  task automatic test_neg_full_scale();
    int bad = 0;
    do_reset();
    step(-32768);
    checks++;
    if (qa !== -4096 || qsa !== -4096 || qma !== -4096) begin
      failures++; $display("FAIL neg_first q=%0d qs=%0d qm=%0d expected -4096", qa, qsa, qma);
    end
    for (int k = 0; k < 200; k++) begin
      step(-32768);
      if (qa > 0 || qsa > 0 || qma > 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL neg_wrap bad_cycles=%0d expected 0", bad);
    end
    checks++;
    if (qa !== NEG_END || qsa !== NEG_END || qma !== NEG_END) begin
      failures++; $display("FAIL neg_settle q=%0d qs=%0d qm=%0d expected %0d", qa, qsa, qma, NEG_END);
    end
  endtask

  task automatic test_sine(input int kind, input string name);
    int     x;
    int     prev_x = 0;
    longint prev_y = 0, peak = 0, vin = 0, vout = 0, ay;
    do_reset();
    for (int k = 0; k < 1024; k++) begin
      case (kind)
        0:       x = int'(20000.0 * $sin(2.0 * PI * k / 256.0));
        1:       x = int'(20000.0 * $sin(PI * k / 2.0));
        default: x = int'(16000.0 * $sin(2.0 * PI * k / 128.0))
                     + int'($urandom_range(0, 8000)) - 4000;
      endcase
      step(x);
      checks++;
      if (qa !== m_a || qsa !== m_a || qma !== m_a) begin
        failures++;
        $display("FAIL %s_model k=%0d q=%0d qs=%0d qm=%0d expected %0d", name, k, qa, qsa, qma, m_a);
      end
      if (k >= 512) begin
        ay = (qa < 0) ? -longint'(qa) : longint'(qa);
        if (ay > peak) peak = ay;
        vin  += (x > prev_x) ? longint'(x - prev_x) : longint'(prev_x - x);
        vout += (qa > prev_y) ? (qa - prev_y) : (prev_y - qa);
      end
      prev_x = x;
      prev_y = qa;
    end
    checks++;
    case (kind)
      0: if (peak <= 17000) begin
           failures++; $display("FAIL %s_gain peak=%0d expected above 17000", name, peak);
         end
      1: if (peak >= 4000) begin
           failures++; $display("FAIL %s_gain peak=%0d expected below 4000", name, peak);
         end
      default: if (vout * 2 >= vin) begin
           failures++; $display("FAIL %s_smooth out_var=%0d in_var=%0d expected under half", name, vout, vin);
         end
    endcase
  endtask

  task automatic test_alpha_override();
    int x;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if (k < 20) x = (k % 2 == 0) ? -32768 : 32767;
      else        x = int'($urandom_range(0, 65535)) - 32768;
      step(x);
      checks++;
      if (qb !== qmb || qb !== m_bq) begin
        failures++; $display("FAIL alpha3000_q k=%0d q=%0d qm=%0d expected %0d", k, qb, qmb, m_bq);
      end
      checks++;
      if (qsb !== m_bs) begin
        failures++; $display("FAIL alpha3000_qs k=%0d qs=%0d expected %0d", k, qsb, m_bs);
      end
    end
  endtask

  task automatic test_passthrough();
    int vec [7] = '{0, 32767, -32768, 1, -1, 12345, -23456};
    for (int k = 0; k < 7; k++) begin
      step(vec[k]);
      checks++;
      if (qc !== vec[k] || qsc !== vec[k] || qmc !== vec[k]) begin
        failures++;
        $display("FAIL passthrough k=%0d q=%0d qs=%0d qm=%0d expected %0d", k, qc, qsc, qmc, vec[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_neg_full_scale();
    test_sine(0, "sine_low");
    test_sine(1, "sine_high");
    test_sine(2, "sine_noisy");
    test_alpha_override();
    test_passthrough();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
